// File: rtl/riscv_pkg.sv
// Shared core package: memory geometry and the memory-port arbiter's state and latency limits.
package riscv_pkg;

  // Byte-address width of the core's word memory and the matching word-address width.
  localparam int byte_addr_p = 12;
  localparam int addr_p      = byte_addr_p - 2;

  // Largest memory read latency the arbiter's counter is sized for.
  localparam int mem_lat_max_p = 7;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RESP   = 2'd3
  } t_arb_state;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after last_i, as one-hot and index.
module rr_picker
  import riscv_pkg::*;
#(
  parameter  int num_ch_p = 2,
  localparam int idx_w_lp = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
  input  logic [num_ch_p-1:0] req_i,
  input  logic [idx_w_lp-1:0] last_i,
  output logic [num_ch_p-1:0] gnt_o,
  output logic [idx_w_lp-1:0] idx_o,
  output logic                any_o
);

  int                  cand_s;
  logic [num_ch_p-1:0] mask_s;

  // Scan channels starting just after the previous owner; the first one requesting wins.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_s = 0;
    mask_s = '0;
    for (int k = 1; k <= num_ch_p; k++) begin
      cand_s = (int'(last_i) + k) % num_ch_p;
      mask_s = {{(num_ch_p-1){1'b0}}, 1'b1} << cand_s;
      if (!any_o && ((req_i & mask_s) != '0)) begin
        gnt_o = mask_s;
        idx_o = idx_w_lp'(cand_s);
        any_o = 1'b1;
      end else begin
        // An earlier (higher-priority) channel already won, or this one is idle.
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port word memory among num_ch_p requesters.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter  int num_ch_p  = 2,
  parameter  int addr_w_p  = byte_addr_p,
  parameter  int data_w_p  = 32,
  parameter  int mem_lat_p = 1,
  localparam int idx_w_lp  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1,
  localparam int be_w_lp   = data_w_p / 8,
  localparam int cnt_w_lp  = $clog2(mem_lat_max_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [num_ch_p-1:0]                req_i,
  input  logic [num_ch_p-1:0]                we_i,
  input  logic [num_ch_p-1:0][addr_w_p-1:0]  addr_i,
  input  logic [num_ch_p-1:0][data_w_p-1:0]  wdata_i,
  input  logic [num_ch_p-1:0][be_w_lp-1:0]   be_i,
  output logic [num_ch_p-1:0]                gnt_o,
  output logic [num_ch_p-1:0]                rvalid_o,
  output logic [data_w_p-1:0]                rdata_o,
  output logic                               busy_o,
  output logic [addr_w_p-3:0]                mem_addr_o,
  output logic                               mem_rd_en_o,
  output logic                               mem_wr_en_o,
  output logic [be_w_lp-1:0]                 mem_be_o,
  output logic [data_w_p-1:0]                mem_wdata_o,
  input  logic [data_w_p-1:0]                mem_rdata_i
);

  t_arb_state              state_q, state_d;
  // The current owner is always the most recently granted channel, so one
  // register serves as both the latched owner and the round-robin pointer.
  logic [idx_w_lp-1:0]     owner_q, owner_d;
  logic [addr_w_p-3:0]     waddr_q, waddr_d;
  logic                    we_q, we_d;
  logic [be_w_lp-1:0]      be_q, be_d;
  logic [data_w_p-1:0]     wdata_q, wdata_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [data_w_p-1:0]     rdata_q, rdata_d;
  logic [num_ch_p-1:0]     rvalid_q, rvalid_d;

  logic [num_ch_p-1:0]     pick_gnt_s;
  logic [idx_w_lp-1:0]     pick_idx_s;
  logic                    pick_any_s;
  logic                    arb_en_s;
  logic                    access_s;
  logic                    unused_addr_lsb_s;

  rr_picker #(.num_ch_p(num_ch_p)) u_picker (
    .req_i  (req_i),
    .last_i (owner_q),
    .gnt_o  (pick_gnt_s),
    .idx_o  (pick_idx_s),
    .any_o  (pick_any_s)
  );

  assign arb_en_s = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
  assign access_s = (state_q == ARB_ACCESS);

  // Byte-offset bits are deliberately dropped; fold them into a sink.
  always_comb begin
    unused_addr_lsb_s = 1'b0;
    for (int ch = 0; ch < num_ch_p; ch++) begin
      unused_addr_lsb_s = unused_addr_lsb_s ^ (^addr_i[ch][1:0]);
    end
  end

  // Next-state logic: arbitrate in IDLE/RESP, strobe in ACCESS, count latency in WAIT.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    waddr_d  = waddr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    case (state_q)
      ARB_IDLE, ARB_RESP: begin
        if (pick_any_s) begin
          state_d = ARB_ACCESS;
          owner_d = pick_idx_s;
          waddr_d = addr_i[pick_idx_s][addr_w_p-1:2];
          we_d    = we_i[pick_idx_s];
          be_d    = be_i[pick_idx_s];
          wdata_d = wdata_i[pick_idx_s];
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ACCESS: begin
        cnt_d   = cnt_w_lp'(mem_lat_p);
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q - {{(cnt_w_lp-1){1'b0}}, 1'b1};
        if (cnt_q == {{(cnt_w_lp-1){1'b0}}, 1'b1}) begin
          state_d  = ARB_RESP;
          rvalid_d = {{(num_ch_p-1){1'b0}}, 1'b1} << owner_q;
          if (we_q) begin
            rdata_d = rdata_q;
          end else begin
            rdata_d = mem_rdata_i;
          end
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and latched-transaction registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= idx_w_lp'(num_ch_p - 1);
      waddr_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      waddr_q  <= waddr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Grant is combinational but forced low while reset is asserted.
  assign gnt_o       = (rstn_i && arb_en_s) ? pick_gnt_s : '0;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state_q != ARB_IDLE);
  assign mem_rd_en_o = access_s & ~we_q;
  assign mem_wr_en_o = access_s & we_q;
  assign mem_addr_o  = access_s ? waddr_q : '0;
  assign mem_be_o    = access_s ? be_q : '0;
  assign mem_wdata_o = access_s ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: 2-channel/latency-1 and 3-channel/latency-3 instances.
module tb_mem_port_arbiter;

  logic clk;
  logic rstn;

  // Instance A: 2 channels, latency 1
  logic [1:0]        req_a, we_a, gnt_a, rvalid_a;
  logic [1:0][11:0]  addr_a;
  logic [1:0][31:0]  wdata_a;
  logic [1:0][3:0]   be_a;
  logic [31:0]       rdata_a, mwd_a, mrd_a;
  logic              busy_a, rd_a, wr_a;
  logic [9:0]        maddr_a;
  logic [3:0]        mbe_a;

  // Instance B: 3 channels, latency 3
  logic [2:0]        req_b, we_b, gnt_b, rvalid_b;
  logic [2:0][11:0]  addr_b;
  logic [2:0][31:0]  wdata_b;
  logic [2:0][3:0]   be_b;
  logic [31:0]       rdata_b, mwd_b, mrd_b;
  logic              busy_b, rd_b, wr_b;
  logic [9:0]        maddr_b;
  logic [3:0]        mbe_b;

  int total_cnt = 0;
  int bad_cnt   = 0;

  mem_port_arbiter #(.num_ch_p(2), .addr_w_p(12), .data_w_p(32), .mem_lat_p(1)) u_dut_a (
    .clk_i(clk), .rstn_i(rstn), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .be_i(be_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .busy_o(busy_a), .mem_addr_o(maddr_a), .mem_rd_en_o(rd_a),
    .mem_wr_en_o(wr_a), .mem_be_o(mbe_a), .mem_wdata_o(mwd_a), .mem_rdata_i(mrd_a)
  );

  mem_port_arbiter #(.num_ch_p(3), .addr_w_p(12), .data_w_p(32), .mem_lat_p(3)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .be_i(be_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .busy_o(busy_b), .mem_addr_o(maddr_b), .mem_rd_en_o(rd_b),
    .mem_wr_en_o(wr_b), .mem_be_o(mbe_b), .mem_wdata_o(mwd_b), .mem_rdata_i(mrd_b)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; callers then drive inputs and wait #1 to check.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_a;
    logic [2:0] exp_b;
    rstn = 1'b0;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; be_a = '0; mrd_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; be_b = '0; mrd_b = '0;

    // Reset state, including grant suppressed while requests are present
    cyc(); cyc();
    req_a = 2'b11;
    #1;
    check_val("rst_gnt", gnt_a, 2'b00);
    check_val("rst_rvalid", rvalid_a, 2'b00);
    check_val("rst_rdata", rdata_a, 32'h0);
    check_val("rst_busy", busy_a, 1'b0);
    check_val("rst_rd", rd_a, 1'b0);
    check_val("rst_wr", wr_a, 1'b0);
    check_val("rst_maddr", maddr_a, 10'h0);
    req_a = 2'b00;
    cyc(); rstn = 1'b1;
    cyc();

    // Single read on ch0, latency 1
    cyc(); req_a = 2'b01; addr_a[0] = 12'h010; #1;
    check_val("rd_gnt", gnt_a, 2'b01);
    cyc(); req_a = 2'b00; #1;
    check_val("rd_rden", rd_a, 1'b1);
    check_val("rd_wren", wr_a, 1'b0);
    check_val("rd_maddr", maddr_a, 10'h004);
    check_val("rd_busy", busy_a, 1'b1);
    cyc(); mrd_a = 32'hDEADBEEF; #1;
    check_val("rd_wait_rden", rd_a, 1'b0);
    check_val("rd_wait_rvalid", rvalid_a, 2'b00);
    cyc(); mrd_a = 32'h0; #1;
    check_val("rd_rvalid", rvalid_a, 2'b01);
    check_val("rd_rdata", rdata_a, 32'hDEADBEEF);
    cyc(); #1;
    check_val("rd_rvalid_clr", rvalid_a, 2'b00);
    check_val("rd_idle", busy_a, 1'b0);

    // Write on ch1 with byte enables 0011
    cyc(); req_a = 2'b10; we_a = 2'b10; addr_a[1] = 12'h020;
    wdata_a[1] = 32'h12345678; be_a[1] = 4'b0011; #1;
    check_val("wr_gnt", gnt_a, 2'b10);
    cyc(); req_a = 2'b00; #1;
    check_val("wr_wren", wr_a, 1'b1);
    check_val("wr_rden", rd_a, 1'b0);
    check_val("wr_maddr", maddr_a, 10'h008);
    check_val("wr_mbe", mbe_a, 4'b0011);
    check_val("wr_mwdata", mwd_a, 32'h12345678);
    cyc(); mrd_a = 32'hFFFFFFFF; #1;
    check_val("wr_wait_wren", wr_a, 1'b0);
    check_val("wr_wait_mwdata", mwd_a, 32'h0);
    cyc(); #1;
    check_val("wr_rvalid", rvalid_a, 2'b10);
    check_val("wr_rdata_kept", rdata_a, 32'hDEADBEEF);
    cyc(); mrd_a = 32'hA5A5A5A5; we_a = 2'b00; #1;
    check_val("wr_idle", busy_a, 1'b0);

    // Fair alternation: both channels request continuously, last owner was ch1
    for (int k = 0; k < 10; k++) begin
      cyc(); req_a = 2'b11; #1;
      if (k % 3 == 0) exp_a = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      else exp_a = 2'b00;
      check_val($sformatf("alt_gnt_%0d", k), gnt_a, exp_a);
      if (k >= 1) check_val($sformatf("alt_busy_%0d", k), busy_a, 1'b1);
    end
    cyc(); req_a = 2'b00; #1;
    check_val("alt_busy_tail", busy_a, 1'b1);
    cyc();
    cyc(); #1;
    check_val("alt_last_rvalid", rvalid_a, 2'b10);
    check_val("alt_last_rdata", rdata_a, 32'hA5A5A5A5);
    cyc(); #1;
    check_val("alt_idle", busy_a, 1'b0);

    // Reset during WAIT: ch0 was last owner, so without reset ch1 would win next
    cyc(); req_a = 2'b01; #1;
    check_val("mrst_gnt", gnt_a, 2'b01);
    cyc(); req_a = 2'b00;
    cyc(); #1;
    check_val("mrst_in_wait", busy_a, 1'b1);
    rstn = 1'b0; req_a = 2'b11; #1;
    check_val("mrst_gnt0", gnt_a, 2'b00);
    check_val("mrst_rvalid0", rvalid_a, 2'b00);
    check_val("mrst_rdata0", rdata_a, 32'h0);
    check_val("mrst_busy0", busy_a, 1'b0);
    check_val("mrst_rd0", rd_a, 1'b0);
    check_val("mrst_wr0", wr_a, 1'b0);
    cyc(); req_a = 2'b00; rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      check_val($sformatf("mrst_no_rvalid_%0d", k), rvalid_a, 2'b00);
      check_val($sformatf("mrst_idle_%0d", k), busy_a, 1'b0);
    end
    cyc(); req_a = 2'b11; #1;
    check_val("mrst_ch0_first", gnt_a, 2'b01);
    cyc(); req_a = 2'b00;
    repeat (4) cyc();

    // Longer latency read on instance B (latency 3), memory data changes before valid
    cyc(); req_b = 3'b001; addr_b[0] = 12'h040; #1;
    check_val("lat_gnt", gnt_b, 3'b001);
    cyc(); req_b = 3'b000; #1;
    check_val("lat_rden", rd_b, 1'b1);
    check_val("lat_maddr", maddr_b, 10'h010);
    cyc(); mrd_b = 32'h11111111; #1;
    check_val("lat_rvalid_t2", rvalid_b, 3'b000);
    cyc(); mrd_b = 32'h22222222; #1;
    check_val("lat_rvalid_t3", rvalid_b, 3'b000);
    cyc(); mrd_b = 32'hCAFEF00D; #1;
    check_val("lat_rvalid_t4", rvalid_b, 3'b000);
    cyc(); mrd_b = 32'h0; #1;
    check_val("lat_rvalid_t5", rvalid_b, 3'b001);
    check_val("lat_rdata", rdata_b, 32'hCAFEF00D);

    // Lone requester ch2 on 3-channel instance: grant every 5 cycles, none in ACCESS/WAIT
    for (int k = 0; k < 11; k++) begin
      cyc(); req_b = 3'b100; #1;
      exp_b = (k % 5 == 0) ? 3'b100 : 3'b000;
      check_val($sformatf("solo_gnt_%0d", k), gnt_b, exp_b);
      exp_b = ((k % 5 == 0) && (k > 0)) ? 3'b100 : 3'b000;
      check_val($sformatf("solo_rvalid_%0d", k), rvalid_b, exp_b);
    end
    req_b = 3'b000;
    repeat (8) cyc();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
